local_cycle_controller: RTL

//  Sequences 68030 local bus cycles for the on-card ROM, RAM and serial regions: inserts per-region wait

---
 rtl/local_bus_pkg.sv | 29 ++
 rtl/bus_watchdog.sv | 40 ++++
 rtl/local_cycle_controller.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/local_bus_pkg.sv
// Shared encodings for the 68030 local bus cycle controller: FSM states, regions,
// DSACK port-width codes and active-low strobe levels.
package local_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RGN_ROM    = 2'd0,
        RGN_RAM    = 2'd1,
        RGN_SERIAL = 2'd2
    } region_t;

    localparam logic [1:0] DSACK_32   = 2'b00;
    localparam logic [1:0] DSACK_8    = 2'b10;
    localparam logic [1:0] DSACK_NONE = 2'b11;

    localparam logic ACTIVE   = 1'b0;
    localparam logic INACTIVE = 1'b1;

    // RAM is the only 32-bit port; ROM and serial answer as 8-bit ports.
    function automatic logic [1:0] region_dsack(input region_t region);
        return (region == RGN_RAM) ? DSACK_32 : DSACK_8;
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Bus-cycle watchdog: counts AS-asserted clocks with no acknowledge and latches BERR
// until AS is released. Instantiated only when BUS_WATCHDOG_EN is defined.
module bus_watchdog
    import local_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic cpu_as,
    input  logic dsack_seen,
    output logic cpu_berr
);

    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic             r_berr;

    // An acknowledge on the edge that would time out clears the count first, so DSACK wins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_berr <= INACTIVE;
        end else if (cpu_as) begin
            r_cnt  <= '0;
            r_berr <= INACTIVE;
        end else if (dsack_seen) begin
            r_cnt  <= '0;
        end else if (r_cnt == LP_TIMEOUT) begin
            r_berr <= ACTIVE;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign cpu_berr = r_berr;

endmodule

// File: rtl/local_cycle_controller.sv
// Local bus cycle sequencer for on-card ROM, RAM and serial: wait states, DSACK width,
// registered device strobes. Optional bus watchdog enabled by defining BUS_WATCHDOG_EN.
module local_cycle_controller
    import local_bus_pkg::*;
#(
    parameter int ROM_WAIT       = 3,
    parameter int RAM_WAIT       = 1,
    parameter int SERIAL_WAIT    = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cpu_as,
    input  logic       cpu_ds,
    input  logic       cpu_rw,
    input  logic       request_rom,
    input  logic       request_ram,
    input  logic       request_serial,
    input  logic [1:0] ext_dsack,
    output logic [1:0] cpu_dsack,
    output logic       cpu_berr,
    output logic       rom_oe,
    output logic       ram_we,
    output logic       ram_oe,
    output logic       serial_cs,
    output logic [1:0] dbg_state
);

    localparam logic [CNT_W-1:0] LP_ROM_WAIT    = CNT_W'(ROM_WAIT);
    localparam logic [CNT_W-1:0] LP_RAM_WAIT    = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] LP_SERIAL_WAIT = CNT_W'(SERIAL_WAIT);

    state_t           r_state, w_state_next;
    region_t          r_region, w_region_next;
    logic             r_rw, w_rw_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [1:0]       r_dsack, w_dsack_next;
    logic             r_rom_oe, r_ram_we, r_ram_oe, r_serial_cs;
    logic             w_rom_oe_next, w_ram_we_next, w_ram_oe_next, w_serial_cs_next;
    logic [2:0]       w_req;
    logic             w_one_req, w_in_cycle;

    assign w_req     = ~{request_serial, request_ram, request_rom};
    assign w_one_req = (w_req == 3'b001) || (w_req == 3'b010) || (w_req == 3'b100);

    // Handshake: a cycle opens when AS is sampled low with one local select; DSACK is held
    // in ACK until the CPU answers by sampling AS high, which closes DSACK and strobes together.
    always_comb begin
        w_state_next  = r_state;
        w_region_next = r_region;
        w_rw_next     = r_rw;
        w_cnt_next    = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (!cpu_as && w_one_req) begin
                    w_state_next = ST_WAIT;
                    w_rw_next    = cpu_rw;
                    if (!request_rom) begin
                        w_region_next = RGN_ROM;
                        w_cnt_next    = LP_ROM_WAIT;
                    end else if (!request_ram) begin
                        w_region_next = RGN_RAM;
                        w_cnt_next    = LP_RAM_WAIT;
                    end else begin
                        w_region_next = RGN_SERIAL;
                        w_cnt_next    = LP_SERIAL_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cpu_as)            w_state_next = ST_IDLE;
                else if (r_cnt == '0)  w_state_next = ST_ACK;
                else                   w_cnt_next   = r_cnt - 1'b1;
            end
            ST_ACK: begin
                if (cpu_as) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase

        // Strobes start one edge after the cycle opens and drop on the edge that leaves it.
        w_in_cycle       = (r_state != ST_IDLE) && (w_state_next != ST_IDLE);
        w_dsack_next     = (w_state_next == ST_ACK) ? region_dsack(r_region) : DSACK_NONE;
        w_rom_oe_next    = (w_in_cycle && r_region == RGN_ROM && r_rw) ? ACTIVE : INACTIVE;
        w_ram_oe_next    = (w_in_cycle && r_region == RGN_RAM && r_rw) ? ACTIVE : INACTIVE;
        w_ram_we_next    = (w_in_cycle && r_region == RGN_RAM && !r_rw && !cpu_ds) ? ACTIVE : INACTIVE;
        w_serial_cs_next = (w_in_cycle && r_region == RGN_SERIAL) ? ACTIVE : INACTIVE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_region    <= RGN_ROM;
            r_rw        <= 1'b1;
            r_cnt       <= '0;
            r_dsack     <= DSACK_NONE;
            r_rom_oe    <= INACTIVE;
            r_ram_we    <= INACTIVE;
            r_ram_oe    <= INACTIVE;
            r_serial_cs <= INACTIVE;
        end else begin
            r_state     <= w_state_next;
            r_region    <= w_region_next;
            r_rw        <= w_rw_next;
            r_cnt       <= w_cnt_next;
            r_dsack     <= w_dsack_next;
            r_rom_oe    <= w_rom_oe_next;
            r_ram_we    <= w_ram_we_next;
            r_ram_oe    <= w_ram_oe_next;
            r_serial_cs <= w_serial_cs_next;
        end
    end

    assign cpu_dsack = r_dsack;
    assign rom_oe    = r_rom_oe;
    assign ram_we    = r_ram_we;
    assign ram_oe    = r_ram_oe;
    assign serial_cs = r_serial_cs;
    assign dbg_state = r_state;

`ifdef BUS_WATCHDOG_EN
    logic w_dsack_seen;
    assign w_dsack_seen = (w_dsack_next != DSACK_NONE) || (r_dsack != DSACK_NONE)
                       || (ext_dsack != DSACK_NONE);

    bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clock      (clock),
        .reset      (reset),
        .cpu_as     (cpu_as),
        .dsack_seen (w_dsack_seen),
        .cpu_berr   (cpu_berr)
    );
`else
    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
    logic w_unused;
    assign w_unused = ^{ext_dsack, LP_TIMEOUT};
    assign cpu_berr = INACTIVE;
`endif

endmodule
